// File: rtl/mem_fifo_tester.sv
// Memory-to-memory copy harness: feature memory -> FIFO -> weight memory.
// Loaded on port_A, streamed on start, read back on port_D.
module mem_fifo_tester #(
  parameter int DATA_W     = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] port_A,
  input  logic              W_en,
  input  logic              s_sig,
  input  logic              R_en,
  output logic [DATA_W-1:0] port_D,
  output logic              xfer_busy,
  output logic              xfer_done
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int DL = MEM_DEPTH - 1;
  localparam logic [AW:0]   SRC_END  = MEM_DEPTH[AW:0];
  localparam logic [AW-1:0] DST_LAST = DL[AW-1:0];

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0]     wa_q, wa_d;
  logic [AW:0]       src_q, src_d;
  logic [AW-1:0]     dst_q, dst_d;
  logic [AW-1:0]     ra_q, ra_d;
  logic [FW:0]       wp_q, wp_d;
  logic [FW:0]       rp_q, rp_d;
  logic [DATA_W-1:0] pd_q, pd_d;

  logic [DATA_W-1:0] feat_mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] wgt_mem_q  [MEM_DEPTH];
  logic [DATA_W-1:0] fifo_q     [FIFO_DEPTH];

  logic feat_we;
  logic fifo_we;
  logic wgt_we;
  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[FW] != rp_q[FW]) &&
                 (wp_q[FW-1:0] == rp_q[FW-1:0]);

  assign push = (state_q == XFER) && !full &&
                (src_q != SRC_END);
  assign pop  = (state_q == XFER) && !empty;

  // Next-state, counter and write-enable logic
  always_comb begin
    state_d = state_q;
    wa_d    = wa_q;
    src_d   = src_q;
    dst_d   = dst_q;
    ra_d    = ra_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    pd_d    = pd_q;
    feat_we = 1'b0;
    fifo_we = 1'b0;
    wgt_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (W_en) begin
          feat_we = 1'b1;
          wa_d    = wa_q + AW'(1);
        end
        if (R_en) begin
          pd_d = wgt_mem_q[ra_q];
          ra_d = ra_q + AW'(1);
        end
        if (s_sig) begin
          state_d = XFER;
          src_d   = '0;
          dst_d   = '0;
          ra_d    = '0;
          wp_d    = '0;
          rp_d    = '0;
        end
      end
      XFER: begin
        if (push) begin
          fifo_we = 1'b1;
          src_d   = src_q + (AW+1)'(1);
          wp_d    = wp_q + (FW+1)'(1);
        end
        if (pop) begin
          wgt_we = 1'b1;
          dst_d  = dst_q + AW'(1);
          rp_d   = rp_q + (FW+1)'(1);
          if (dst_q == DST_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (R_en) begin
          pd_d = wgt_mem_q[ra_q];
          ra_d = ra_q + AW'(1);
        end
        if (!s_sig) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst) begin
      feat_we = 1'b0;
      fifo_we = 1'b0;
      wgt_we  = 1'b0;
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wa_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      ra_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      wa_q    <= wa_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      ra_q    <= ra_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      pd_q    <= pd_d;
    end
  end

  // Storage arrays keep contents across reset
  always_ff @(posedge clk) begin
    if (feat_we) begin
      feat_mem_q[wa_q] <= port_A;
    end
    if (fifo_we) begin
      fifo_q[wp_q[FW-1:0]] <= feat_mem_q[src_q[AW-1:0]];
    end
    if (wgt_we) begin
      wgt_mem_q[dst_q] <= fifo_q[rp_q[FW-1:0]];
    end
  end

  assign port_D    = pd_q;
  assign xfer_busy = (state_q == XFER);
  assign xfer_done = (state_q == DONE);

endmodule

// File: tb/tb_mem_fifo_tester.sv
// Scoreboard bench for mem_fifo_tester.
// Reads push expected port_D values; a monitor pops and compares.
module tb_mem_fifo_tester;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] port_A = '0;
  logic       W_en = 1'b0;
  logic       s_sig = 1'b0;
  logic       R_en = 1'b0;
  logic [7:0] port_D;
  logic       xfer_busy;
  logic       xfer_done;

  mem_fifo_tester dut (
    .clk       (clk),
    .rst       (rst),
    .port_A    (port_A),
    .W_en      (W_en),
    .s_sig     (s_sig),
    .R_en      (R_en),
    .port_D    (port_D),
    .xfer_busy (xfer_busy),
    .xfer_done (xfer_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] feat_m [16];
  logic [7:0] wgt_m  [16];
  logic [3:0] wa_m = '0;
  logic [3:0] ra_m = '0;
  logic [7:0] pd_m = '0;
  logic [7:0] exp_q [$];

  logic [7:0] init_v [16] = '{8'd4, 8'd14, 8'd24, 8'd42,
                              8'd141, 8'd243, 8'd41, 8'd134,
                              8'd204, 8'd124, 8'd104, 8'd24,
                              8'd34, 8'd74, 8'd84, 8'd95};

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every sampled read request yields one port_D check
  always @(posedge clk) begin
    if (R_en && !rst) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL port_D: got %0d with no expected value", port_D);
      end else begin
        chk("port_D", 32'(port_D), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_reset();
    wa_m = '0;
    ra_m = '0;
    pd_m = '0;
  endtask

  // Called right after a negedge: request a read for the next edge
  task automatic rd_push(input bit active);
    R_en = 1'b1;
    if (active) begin
      pd_m = wgt_m[ra_m];
      ra_m = ra_m + 4'd1;
    end
    exp_q.push_back(pd_m);
  endtask

  task automatic load_val(input logic [7:0] v);
    @(negedge clk);
    W_en = 1'b1;
    port_A = v;
    feat_m[wa_m] = v;
    wa_m = wa_m + 4'd1;
  endtask

  task automatic load_end();
    @(negedge clk);
    W_en = 1'b0;
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        R_en = 1'b0;
        @(negedge clk);
      end
      rd_push(1'b1);
    end
    @(negedge clk);
    R_en = 1'b0;
  endtask

  task automatic do_xfer(input int abort_at);
    @(negedge clk);
    s_sig = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_e0", 32'(xfer_busy), 32'd1);
    chk("done_e0", 32'(xfer_done), 32'd0);
    ra_m = '0;
    for (int e = 1; e <= 17; e++) begin
      @(negedge clk);
      port_A = 8'd99;
      W_en = (e <= 4);
      if (e <= 4) rd_push(1'b0);
      else R_en = 1'b0;
      if (abort_at == e) begin
        rst = 1'b1;
        s_sig = 1'b0;
      end
      @(posedge clk);
      #1;
      if (abort_at == e) begin
        chk("abort_busy", 32'(xfer_busy), 32'd0);
        chk("abort_done", 32'(xfer_done), 32'd0);
        chk("abort_pd", 32'(port_D), 32'd0);
        for (int k = 0; k < e - 2; k++) wgt_m[k] = feat_m[k];
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      chk($sformatf("busy_e%0d", e), 32'(xfer_busy),
          32'(e < 17));
      chk($sformatf("done_e%0d", e), 32'(xfer_done),
          32'(e == 17));
    end
    for (int k = 0; k < 16; k++) wgt_m[k] = feat_m[k];
  endtask

  task automatic leave_done();
    @(negedge clk);
    W_en = 1'b1;
    port_A = 8'd77;
    @(posedge clk);
    #1;
    chk("done_hold", 32'(xfer_done), 32'd1);
    @(negedge clk);
    W_en = 1'b0;
    s_sig = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_done", 32'(xfer_done), 32'd0);
    chk("idle_busy", 32'(xfer_busy), 32'd0);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("rst_pd", 32'(port_D), 32'd0);
    chk("rst_busy", 32'(xfer_busy), 32'd0);
    chk("rst_done", 32'(xfer_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 16; i++) load_val(init_v[i]);
    load_end();
    do_xfer(0);
    read_n(17);
    leave_done();

    for (int i = 0; i < 16; i++) load_val(8'($urandom));
    load_end();
    do_xfer(8);
    read_n(8);

    do_xfer(0);
    read_n(16);
    leave_done();

    for (int i = 0; i < 16; i++) load_val(8'($urandom));
    load_val(8'd200);
    load_end();
    do_xfer(0);
    read_n(16);
    leave_done();

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
